// File: rtl/alu_result_serializer.sv
// Serialises 2*DATA_WIDTH-bit ALU results into a byte stream (low byte first) for a TX FIFO.
// Optional feature: define ALU_SER_DROP_CNT_EN to add the saturating DROP_CNT counter/port.
module alu_result_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VALID,
  input  logic                    FIFO_FULL,
  output logic [DATA_WIDTH-1:0]   WR_DATA,
  output logic                    WR_INC,
  output logic                    BUSY,
  output logic                    OVERFLOW
`ifdef ALU_SER_DROP_CNT_EN
  ,
  output logic [7:0]              DROP_CNT
`endif
);

  localparam int RW = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} state_t;

  state_t          state, state_d;
  logic [RW-1:0]   active, active_d;
  logic [RW-1:0]   pending, pending_d;
  logic            pend_v, pend_v_d;
  logic            hi_write;
  logic            drop;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      active   <= '0;
      pending  <= '0;
      pend_v   <= 1'b0;
      OVERFLOW <= 1'b0;
    end else begin
      state    <= state_d;
      active   <= active_d;
      pending  <= pending_d;
      pend_v   <= pend_v_d;
      OVERFLOW <= drop;
    end
  end

  always_comb begin
    state_d   = state;
    active_d  = active;
    pending_d = pending;
    pend_v_d  = pend_v;
    hi_write  = 1'b0;
    drop      = 1'b0;
    WR_INC    = 1'b0;
    WR_DATA   = '0;

    case (state)
      IDLE: begin
        if (ALU_OUT_VALID) begin
          active_d = ALU_OUT;
          state_d  = SEND_LO;
        end
      end
      SEND_LO: begin
        WR_DATA = active[DATA_WIDTH-1:0];
        WR_INC  = !FIFO_FULL;
        if (!FIFO_FULL) state_d = SEND_HI;
      end
      SEND_HI: begin
        WR_DATA  = active[RW-1:DATA_WIDTH];
        WR_INC   = !FIFO_FULL;
        hi_write = !FIFO_FULL;
        if (hi_write) begin
          if (pend_v) begin
            active_d = pending;
            pend_v_d = 1'b0;
            state_d  = SEND_LO;
          end else begin
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state != IDLE && ALU_OUT_VALID) begin
      // With PENDING empty and the last byte leaving, the new result would pass
      // through PENDING for zero cycles, so it goes straight to ACTIVE instead.
      if (hi_write && !pend_v) begin
        active_d = ALU_OUT;
        state_d  = SEND_LO;
      end else if (!pend_v || hi_write) begin
        pending_d = ALU_OUT;
        pend_v_d  = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end

    // Reset aborts the result immediately, including the byte offered this cycle.
    if (RST) WR_INC = 1'b0;
  end

  assign BUSY = (state != IDLE);

`ifdef ALU_SER_DROP_CNT_EN
  always_ff @(posedge CLK) begin
    if (RST)
      DROP_CNT <= '0;
    else if (drop && DROP_CNT != 8'hFF)
      DROP_CNT <= DROP_CNT + 8'd1;
  end
`endif

endmodule

// File: doc/alu_result_serializer.md
ALU_RESULT_SERIALIZER -- requirements
Module: alu_result_serializer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, byte width of the output stream; ALU results are 2*DATA_WIDTH bits.
REQ-002 CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 RST  input  1  reset; synchronous and active-high.
REQ-004 ALU_OUT  input  2*DATA_WIDTH  ALU result word.
REQ-005 ALU_OUT_VALID  input  1  one-cycle strobe; each high cycle SHALL be one new result.
REQ-006 FIFO_FULL  input  1  downstream TX FIFO full; no write is allowed while high.
REQ-007 WR_DATA  output  DATA_WIDTH  byte to TX FIFO.
REQ-008 WR_INC  output  1  FIFO write enable; one byte per high cycle.
REQ-009 BUSY  output  1  high whenever state is not IDLE.
REQ-010 OVERFLOW  output  1  one-cycle pulse when a result is dropped.
REQ-011 DROP_CNT  output  8  dropped-result count; present only with ALU_SER_DROP_CNT_EN.

Function
REQ-012 Storage SHALL be two result registers: ACTIVE (being sent) and PENDING (with valid flag PEND_V).
REQ-013 FSM states SHALL be IDLE, SEND_LO, SEND_HI.
REQ-014 IDLE: strobe -> ALU_OUT loaded into ACTIVE, next state SEND_LO.
REQ-015 SEND_LO: WR_DATA = ACTIVE[DATA_WIDTH-1:0]; WR_INC = !FIFO_FULL; on write -> SEND_HI, else stay.
REQ-016 SEND_HI: WR_DATA = ACTIVE[2*DATA_WIDTH-1:DATA_WIDTH]; WR_INC = !FIFO_FULL; stay while FIFO_FULL.
REQ-017 On SEND_HI write: PEND_V=1 -> PENDING copied to ACTIVE, PEND_V cleared, next SEND_LO; PEND_V=0 -> IDLE.
REQ-018 WR_INC and WR_DATA SHALL be combinational from state, ACTIVE and FIFO_FULL; WR_INC SHALL be 0 in IDLE and WR_DATA SHALL be 0 in IDLE.
REQ-019 Byte order SHALL be low byte first, high byte second, with no gap when FIFO_FULL stays low.
REQ-020 Latency: strobe in cycle n from IDLE, FIFO not full -> low byte written in n+1, high byte in n+2.
REQ-021 Strobe while BUSY and PEND_V=0 SHALL load PENDING and set PEND_V.
REQ-022 Strobe while BUSY, PEND_V=1, and SEND_HI write in same cycle SHALL load PENDING (old PENDING moves to ACTIVE); no drop.
REQ-023 Strobe while BUSY, PEND_V=1, no SEND_HI write that cycle SHALL drop the new result, leave ACTIVE/PENDING unchanged and pulse OVERFLOW next cycle.
REQ-024 FIFO_FULL asserted mid-result SHALL stall only; no byte lost, repeated or reordered.
REQ-025 Results SHALL be emitted in strobe order; ALU_OUT is sampled only in strobe cycles.

Reset
REQ-026 RST=1 SHALL force state IDLE, ACTIVE=0, PENDING=0, PEND_V=0, OVERFLOW=0, DROP_CNT=0 at the next CLK edge.
REQ-027 Reset mid-result SHALL discard ACTIVE and PENDING; no further bytes of the aborted result SHALL be written.
REQ-028 A strobe coincident with RST=1 SHALL be ignored.

Configuration
REQ-029 Macro ALU_SER_DROP_CNT_EN defined: DROP_CNT port and 8-bit counter exist, +1 per drop, saturating at 255, cleared only by reset.
REQ-030 Macro ALU_SER_DROP_CNT_EN undefined: no DROP_CNT port or counter; OVERFLOW behaviour unchanged.

Verification
REQ-031 Single result: ALU_OUT=16'hA55A strobe, FIFO_FULL=0 -> WR_DATA 8'h5A then 8'hA5 on consecutive cycles, BUSY low after.
REQ-032 Backpressure: ALU_OUT=16'h1234, FIFO_FULL high 3 cycles after low byte -> 8'h34, 3 idle cycles, 8'h12; exactly 2 WR_INC pulses.
REQ-033 Back-to-back: strobes 16'h0102, 16'h0304 on consecutive cycles -> bytes 02,01,04,03 on 4 consecutive cycles, no OVERFLOW.
REQ-034 Overflow: FIFO_FULL=1, strobes 16'h1111, 16'h2222, 16'h3333 -> OVERFLOW one pulse, DROP_CNT=1 (macro on); after release bytes 11,11,22,22 only.
REQ-035 Reset mid-op: RST=1 in SEND_HI of 16'hBEEF -> no 8'hBE written, BUSY=0, all outputs 0 next cycle.
REQ-036 Saturation (macro on): 300 dropped results -> DROP_CNT=255.
